// File: rtl/irq_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_defs (package)
//  Purpose  : Shared constants and FSM state type for the IRQ vector
//             controller and its fixed-priority encoder.
//  Revision : 1.0  initial release
// ============================================================================
package irq_defs;

  // Default source count and ROM index of IRQ0's vector.
  localparam int c_n_irq_default    = 8;
  localparam int c_vec_base_default = 8;
  localparam int c_cause_w          = $clog2(c_n_irq_default);

  // Controller states, 2-bit registered encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_REQ     = 2'd2,
    ST_SERVICE = 2'd3
  } irq_state_e;

  // Width of a source index; a single-source build still needs one bit.
  function automatic int cause_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : irq_prio_enc
//  Purpose  : Combinational fixed-priority encoder. The lowest set index
//             of req_i wins; valid_o flags that any bit was set.
//  Revision : 1.0  initial release
// ============================================================================
module irq_prio_enc
  import irq_defs::*;
#(
  parameter int N_IRQ = c_n_irq_default,
  parameter int IDX_W = c_cause_w
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest set index is the last write.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_vector_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_vector_ctrl
//  Purpose  : Edge-capturing, maskable interrupt controller. Selects the
//             lowest-index unmasked pending source, fetches its handler
//             address from the external vector ROM and presents it to the
//             CPU with a req/ack handshake, then waits for ERET.
//  Revision : 1.0  initial release
// ============================================================================
module irq_vector_ctrl
  import irq_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int N_IRQ      = c_n_irq_default,
  parameter int VEC_BASE   = c_vec_base_default
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_IRQ-1:0]              i_irq,
  input  logic                          i_mask_we,
  input  logic [N_IRQ-1:0]              i_mask_wdata,
  input  logic                          i_ack,
  input  logic                          i_eret,
  output logic [ADDR_WIDTH-1:0]         o_rom_addr,
  input  logic [DATA_WIDTH-1:0]         i_rom_data,
  output logic                          o_req,
  output logic [DATA_WIDTH-1:0]         o_vector,
  output logic [cause_width(N_IRQ)-1:0] o_cause,
  output logic                          o_busy,
  output logic [N_IRQ-1:0]              o_pending
);

  localparam int CW = cause_width(N_IRQ);

  irq_state_e            state_q, state_d;
  logic [N_IRQ-1:0]      irq_q, pend_q, pend_d, mask_q;
  logic [CW-1:0]         cause_q, cause_d;
  logic [DATA_WIDTH-1:0] vector_q, vector_d;
  logic [N_IRQ-1:0]      w_edge, w_clr, w_active;
  logic [CW-1:0]         w_prio_idx;
  logic                  w_prio_valid;

  assign w_edge   = i_irq & ~irq_q;
  assign w_active = pend_q & mask_q;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .IDX_W (CW)
  ) u_prio (
    .req_i   (w_active),
    .idx_o   (w_prio_idx),
    .valid_o (w_prio_valid)
  );

  // Ack retires the served source; a fresh edge in the same cycle re-arms it.
  always_comb begin
    w_clr = '0;
    if (state_q == ST_REQ && i_ack) begin
      w_clr[cause_q] = 1'b1;
    end
    pend_d = (pend_q & ~w_clr) | w_edge;
  end

  // Next-state logic; once a cause is chosen it is committed until ERET.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    vector_d = vector_q;
    case (state_q)
      ST_IDLE: begin
        if (w_prio_valid) begin
          cause_d = w_prio_idx;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        vector_d = i_rom_data;
        state_d  = ST_REQ;
      end
      ST_REQ: begin
        if (i_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (i_eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, capture, pending and mask registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      irq_q    <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      cause_q  <= '0;
      vector_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= i_irq;
      pend_q   <= pend_d;
      cause_q  <= cause_d;
      vector_q <= vector_d;
      if (i_mask_we) mask_q <= i_mask_wdata;
    end
  end

  // The ROM is read-only, so the address is driven from cause in every state.
  assign o_rom_addr = ADDR_WIDTH'(VEC_BASE) + ADDR_WIDTH'(cause_q);
  assign o_req      = (state_q == ST_REQ);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_vector   = vector_q;
  assign o_cause    = cause_q;
  assign o_pending  = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_vector_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_vector_ctrl
//  Purpose  : Self-checking bench for irq_vector_ctrl. A vector ROM with
//             entry i = 0xBFC0_0000 + 0x80*i sits beside the DUT. Expected
//             requests go into a scoreboard queue; a monitor pops them when
//             o_req rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_vector_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 8;
  localparam int VB = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          ack;
  logic          eret;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          req;
  logic [DW-1:0] vector;
  logic [CW-1:0] cause;
  logic          busy;
  logic [N-1:0]  pending;

  always #5 clk = ~clk;

  // Vector ROM beside the controller.
  assign rom_data = 32'hBFC0_0000 + 32'h80 * DW'(rom_addr);

  irq_vector_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .N_IRQ      (N),
    .VEC_BASE   (VB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_irq        (irq),
    .i_mask_we    (mask_we),
    .i_mask_wdata (mask_wdata),
    .i_ack        (ack),
    .i_eret       (eret),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_req        (req),
    .o_vector     (vector),
    .o_cause      (cause),
    .o_busy       (busy),
    .o_pending    (pending)
  );

  typedef struct packed {
    logic [CW-1:0] cause;
    logic [DW-1:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: pending set, mask, the committed source (-1 = none),
  // cycles elapsed since commitment, and whether the CPU has accepted it.
  logic [N-1:0] m_prev, m_pend, m_mask;
  int           m_cause;
  int           m_age;
  bit           m_acked;

  function automatic bit m_requesting();
    return (m_cause >= 0) && (m_age >= 1) && !m_acked;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = '0;
    m_pend  = '0;
    m_mask  = '0;
    m_cause = -1;
    m_age   = 0;
    m_acked = 1'b0;
    sb_q.delete();
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic [N-1:0] i_irq_v, input bit we, input logic [N-1:0] wd,
                            input bit a, input bit e, input bit r);
    logic [N-1:0] edges, clr, act;
    int low;
    if (r) begin
      model_reset();
      return;
    end
    edges = i_irq_v & ~m_prev;
    clr   = '0;
    if (m_requesting() && a) clr[m_cause] = 1'b1;
    if (m_cause < 0) begin
      act = m_pend & m_mask;
      if (act != '0) begin
        low = 0;
        for (int i = N - 1; i >= 0; i--) if (act[i]) low = i;
        m_cause = low;
        m_age   = 0;
        m_acked = 1'b0;
        sb_q.push_back('{cause: CW'(low), vec: 32'hBFC0_0000 + 32'h80 * DW'(VB + low)});
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (!m_acked) begin
      if (a) m_acked = 1'b1;
    end else if (e) begin
      m_cause = -1;
    end
    m_pend = (m_pend & ~clr) | edges;
    if (we) m_mask = wd;
    m_prev = i_irq_v;
  endtask

  // One cycle: check visible state, drive inputs, advance the model.
  task automatic step(input logic [N-1:0] i_irq_v, input bit we, input logic [N-1:0] wd,
                      input bit a, input bit e, input bit r);
    @(negedge clk);
    check("pending", 32'(pending), 32'(m_pend));
    check("busy", 32'(busy), 32'(m_cause >= 0));
    check("req", 32'(req), 32'(m_requesting()));
    if (m_requesting()) check("cause", 32'(cause), 32'(m_cause));
    irq        = i_irq_v;
    mask_we    = we;
    mask_wdata = wd;
    ack        = a;
    eret       = e;
    rst        = r;
    model_edge(i_irq_v, we, wd, a, e, r);
  endtask

  task automatic idle_until_req();
    for (int k = 0; k < 20 && !m_requesting(); k++) step('0, 0, '0, 0, 0, 0);
  endtask

  // Wait for the request, ack it, optionally pulse lines during SERVICE, then ERET.
  task automatic serve(input logic [N-1:0] pulse);
    idle_until_req();
    step('0, 0, '0, 1, 0, 0);
    if (pulse != '0) begin
      step(pulse, 0, '0, 0, 0, 0);
      step('0, 0, '0, 0, 0, 0);
    end
    step('0, 0, '0, 0, 1, 0);
  endtask

  // Monitor: a rising o_req must match the oldest expected request.
  initial begin : monitor
    logic prev_req;
    exp_t cur;
    prev_req = 1'b0;
    cur      = '0;
    forever begin
      @(posedge clk);
      #2;
      if (req === 1'b1 && prev_req !== 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: cause %0d vector 0x%08h, no request expected", cause, vector);
        end else begin
          cur = sb_q.pop_front();
          check("req_cause", 32'(cause), 32'(cur.cause));
          check("req_vector", vector, cur.vec);
        end
      end else if (req === 1'b1) begin
        check("hold_cause", 32'(cause), 32'(cur.cause));
        check("hold_vector", vector, cur.vec);
      end
      prev_req = req;
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin : stimulus
    logic [N-1:0] irq_r;
    bit           a, e, r, we;
    rst = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eret = 1'b0;
    model_reset();
    @(posedge clk);

    // Single source, exact latency, vector for cause 3.
    step('0, 1, 8'hFF, 0, 0, 0);
    step(8'h08, 0, '0, 0, 0, 0);
    step('0, 0, '0, 0, 0, 0);
    serve('0);

    // Two simultaneous sources: 2 first, then 5.
    step(8'h24, 0, '0, 0, 0, 0);
    step('0, 0, '0, 0, 0, 0);
    serve('0);
    serve('0);

    // Masked source stays pending until enabled.
    step('0, 1, 8'h00, 0, 0, 0);
    step(8'h02, 0, '0, 0, 0, 0);
    repeat (5) step('0, 0, '0, 0, 0, 0);
    step('0, 1, 8'h02, 0, 0, 0);
    serve('0);

    // Held level gives one event; re-pulse during SERVICE is deferred.
    step('0, 1, 8'hFF, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(8'h01, 0, '0, m_requesting(), 0, 0);
    step('0, 0, '0, 0, 0, 0);
    step(8'h01, 0, '0, 0, 0, 0);
    step('0, 0, '0, 0, 0, 0);
    step('0, 0, '0, 0, 1, 0);
    serve('0);

    // Reset while requesting; the late ack is ignored and the mask is cleared.
    step(8'h10, 0, '0, 0, 0, 0);
    step('0, 0, '0, 0, 0, 0);
    idle_until_req();
    step('0, 0, '0, 0, 0, 1);
    step('0, 0, '0, 1, 0, 0);
    step(8'h40, 0, '0, 0, 0, 0);
    repeat (4) step('0, 0, '0, 0, 0, 0);

    // New edge on the served bit in the ack cycle keeps it pending.
    step('0, 1, 8'hFF, 0, 0, 0);
    idle_until_req();
    serve('0);
    step(8'h10, 0, '0, 0, 0, 0);
    step('0, 0, '0, 0, 0, 0);
    idle_until_req();
    step(8'h10, 0, '0, 1, 0, 0);
    step('0, 0, '0, 0, 0, 0);
    step('0, 0, '0, 0, 1, 0);
    serve('0);

    // Randomized traffic, including stray ack/eret and occasional reset.
    irq_r = '0;
    for (int k = 0; k < 3000; k++) begin
      irq_r ^= N'($urandom & $urandom & $urandom);
      we = ($urandom % 16) == 0;
      a  = m_requesting() ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
      e  = (m_cause >= 0 && m_acked) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      r  = ($urandom % 400) == 0;
      step(irq_r, we, N'($urandom | $urandom), a, e, r);
    end

    // Drain everything still pending.
    step('0, 1, 8'hFF, 0, 0, 0);
    for (int k = 0; k < 200 && !(m_cause < 0 && m_pend == '0); k++) step('0, 0, '0, 1, 1, 0);
    repeat (3) step('0, 0, '0, 0, 0, 0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
